// File: rtl/varint_pkg.sv
// Shared types and constants for the varint field decoder.
// State encodings, widths and the zigzag helper.
package varint_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'b001,
    S_DECODE = 3'b010,
    S_OUTPUT = 3'b100
  } state_t;

  localparam int VARINT_MAX_BYTES = 10;
  localparam int VARINT_RAW_W     = 80;
  localparam int VARINT_VAL_W     = 64;
  localparam int VARINT_LEN_W     = 4;

  // protobuf sint mapping: even -> positive, odd -> negative
  function automatic logic [VARINT_VAL_W-1:0] zigzag(
    input logic [VARINT_VAL_W-1:0] a
  );
    return (a >> 1) ^ {VARINT_VAL_W{a[0]}};
  endfunction

endpackage

// File: rtl/varint_field_decoder.sv
// Decodes one little-endian base-128 varint per request,
// one byte per cycle, into a 64-bit field record.
module varint_field_decoder
  import varint_pkg::*;
#(
  parameter int INDEX_W = 8,
  parameter int ZIGZAG  = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    varint_data_valid,
  input  logic [VARINT_RAW_W-1:0] varint_data,
  input  logic [INDEX_W-1:0]      varint_index,
  output logic                    varint_data_accepted,
  output logic                    field_valid,
  input  logic                    field_ready,
  output logic [VARINT_VAL_W-1:0] field_value,
  output logic [INDEX_W-1:0]      field_index,
  output logic [VARINT_LEN_W-1:0] field_len,
  output logic                    field_error,
  output logic [31:0]             field_count
);

  state_t r_state;
  state_t w_next;

  logic [VARINT_RAW_W-1:0] r_data;
  logic [INDEX_W-1:0]      r_index;
  logic [3:0]              r_k;
  logic [VARINT_VAL_W-1:0] r_acc;

  logic [7:0]              w_byte;
  logic [5:0]              w_shamt;
  logic [VARINT_VAL_W-1:0] w_acc;
  logic                    w_last;
  logic                    w_err;
  logic                    w_accept;
  logic                    w_done;

  assign w_byte  = r_data[{r_k, 3'b000} +: 8];
  assign w_shamt = {2'b00, r_k} * 6'd7;
  assign w_acc   = r_acc | ({57'd0, w_byte[6:0]} << w_shamt);
  assign w_last  = ~w_byte[7] | (r_k == 4'd9);
  assign w_err   = (r_k == 4'd9) & (w_byte[7] | (|w_byte[6:1]));

  // gated by reset_n so no pulse leaks out while held in reset
  assign varint_data_accepted = w_accept & reset_n;
  assign field_valid          = (r_state == S_OUTPUT);

  // next-state and handshake strobes
  always_comb begin
    w_next   = S_IDLE;
    w_accept = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = varint_data_valid;
        w_next   = varint_data_valid ? S_DECODE : S_IDLE;
      end
      S_DECODE: begin
        w_done = w_last;
        w_next = w_last ? S_OUTPUT : S_DECODE;
      end
      S_OUTPUT: begin
        w_next = field_ready ? S_IDLE : S_OUTPUT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // capture buffer and byte accumulator
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_index <= '0;
      r_k     <= '0;
      r_acc   <= '0;
    end else if (w_accept) begin
      r_data  <= varint_data;
      r_index <= varint_index;
      r_k     <= '0;
      r_acc   <= '0;
    end else if (r_state == S_DECODE) begin
      r_acc <= w_acc;
      if (!w_last) r_k <= r_k + 4'd1;
    end
  end

  // result registers, loaded once when decode finishes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      field_value <= '0;
      field_index <= '0;
      field_len   <= '0;
      field_error <= 1'b0;
    end else if (w_done) begin
      field_value <= (ZIGZAG != 0) ? zigzag(w_acc) : w_acc;
      field_index <= r_index;
      field_len   <= r_k + 4'd1;
      field_error <= w_err;
    end
  end

  // saturating handoff counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      field_count <= '0;
    end else if (field_valid && field_ready &&
                 field_count != 32'hFFFF_FFFF) begin
      field_count <= field_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_varint_field_decoder.sv
// Randomized self-checking bench for varint_field_decoder.
// Raw and zigzag instances share stimulus.
module tb_varint_field_decoder;

  logic        clk;
  logic        reset_n;
  logic        vld;
  logic [79:0] data;
  logic [7:0]  idx;
  logic        rdy;

  logic        acc,   acc_z;
  logic        fv,    fv_z;
  logic [63:0] fval,  fval_z;
  logic [7:0]  fidx,  fidx_z;
  logic [3:0]  flen,  flen_z;
  logic        ferr,  ferr_z;
  logic [31:0] fcnt,  fcnt_z;

  int n_cmp;
  int n_bad;
  int cnt_exp;

  varint_field_decoder #(.INDEX_W(8), .ZIGZAG(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .varint_data_valid(vld), .varint_data(data),
    .varint_index(idx), .varint_data_accepted(acc),
    .field_valid(fv), .field_ready(rdy),
    .field_value(fval), .field_index(fidx),
    .field_len(flen), .field_error(ferr),
    .field_count(fcnt)
  );

  varint_field_decoder #(.INDEX_W(8), .ZIGZAG(1)) dut_z (
    .clk(clk), .reset_n(reset_n),
    .varint_data_valid(vld), .varint_data(data),
    .varint_index(idx), .varint_data_accepted(acc_z),
    .field_valid(fv_z), .field_ready(rdy),
    .field_value(fval_z), .field_index(fidx_z),
    .field_len(flen_z), .field_error(ferr_z),
    .field_count(fcnt_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference: sum of 7-bit groups, stop at first byte with msb clear
  function automatic void model(input  logic [79:0] d,
                                output logic [63:0] v,
                                output int          len,
                                output logic        err);
    logic [7:0] b;
    v   = '0;
    len = 10;
    err = 1'b0;
    for (int k = 0; k < 10; k++) begin
      b = d[8*k +: 8];
      v = v | (64'(b[6:0]) << (7*k));
      if (!b[7]) begin
        len = k + 1;
        break;
      end
    end
    if (len == 10) begin
      b   = d[79:72];
      err = b[7] || (b[6:1] != 6'd0);
    end
  endfunction

  function automatic logic [63:0] zig(input logic [63:0] v);
    if (v % 2 == 0) return v / 2;
    return 64'hFFFF_FFFF_FFFF_FFFF - (v / 2);
  endfunction

  task automatic check_result(input logic [63:0] ev,
                              input int el,
                              input logic ee,
                              input logic [7:0] ei);
    chk("valid",    fv,     1);
    chk("value",    fval,   ev);
    chk("len",      flen,   el);
    chk("error",    ferr,   ee);
    chk("index",    fidx,   ei);
    chk("zz_valid", fv_z,   1);
    chk("zz_value", fval_z, zig(ev));
  endtask

  task automatic do_item(input logic [79:0] d,
                         input logic [7:0]  ix,
                         input int          hold);
    logic [63:0] ev;
    int          el;
    logic        ee;
    int          n;
    int          lat;
    logic [95:0] g;
    model(d, ev, el, ee);
    @(posedge clk); #1;
    vld  = 1'b1;
    data = d;
    idx  = ix;
    n = 0;
    @(negedge clk);
    while (!acc && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_seen", acc, 1);
    @(posedge clk); #1;
    g    = {$urandom, $urandom, $urandom};
    vld  = 1'($urandom_range(0, 1));
    data = g[79:0];
    idx  = 8'($urandom);
    lat  = 0;
    do begin
      @(negedge clk);
      lat++;
      chk("no_accept_busy", acc, 0);
    end while (!fv && lat < 20);
    chk("latency", lat, el + 1);
    check_result(ev, el, ee, ix);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      vld = 1'b1;
      @(negedge clk);
      chk("bp_accept", acc, 0);
      check_result(ev, el, ee, ix);
    end
    @(posedge clk); #1;
    vld = 1'b0;
    rdy = 1'b1;
    @(negedge clk);
    check_result(ev, el, ee, ix);
    @(posedge clk); #1;
    rdy = 1'b0;
    cnt_exp++;
    @(negedge clk);
    chk("count",       fcnt, 64'(cnt_exp));
    chk("valid_drops", fv,   0);
  endtask

  function automatic logic [79:0] rand_varint();
    logic [79:0] d;
    logic [7:0]  b;
    int          l;
    l = $urandom_range(1, 10);
    for (int k = 0; k < 10; k++) begin
      b = 8'($urandom);
      if (k < l - 1)               b[7] = 1'b1;
      else if (k == l - 1 && l < 10) b[7] = 1'b0;
      if (k == 9 && $urandom_range(0, 1) == 1)
        b = 8'($urandom_range(0, 1));
      d[8*k +: 8] = b;
    end
    return d;
  endfunction

  initial begin
    logic [79:0] d;
    int          n;
    n_cmp   = 0;
    n_bad   = 0;
    cnt_exp = 0;
    reset_n = 1'b0;
    vld     = 1'b0;
    data    = '0;
    idx     = '0;
    rdy     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", fv,   0);
    chk("rst_value", fval, 0);
    chk("rst_len",   flen, 0);
    chk("rst_count", fcnt, 0);
    chk("rst_acc",   acc,  0);
    #2 reset_n = 1'b1;

    do_item(80'h01, 8'd5, 0);
    do_item(80'h02AC, 8'd9, 2);
    do_item({8'h01, {9{8'hFF}}}, 8'd1, 0);
    do_item({8'h80, {9{8'hFF}}}, 8'd2, 1);
    do_item({8'h02, {9{8'hFF}}}, 8'd3, 0);
    do_item(80'h03, 8'd4, 5);
    do_item({8'h55, 8'hAA, 8'h7F, 8'h81}, 8'd6, 0);

    for (int i = 0; i < 40; i++)
      do_item(rand_varint(), 8'($urandom), $urandom_range(0, 3));

    // reset while a 10-byte varint is mid-decode
    d = {8'h01, {9{8'hFF}}};
    @(posedge clk); #1;
    vld  = 1'b1;
    data = d;
    n = 0;
    @(negedge clk);
    while (!acc && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_accept_seen", acc, 1);
    @(posedge clk); #1;
    vld = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", fv,   0);
    chk("mid_rst_value", fval, 0);
    chk("mid_rst_index", fidx, 0);
    chk("mid_rst_len",   flen, 0);
    chk("mid_rst_error", ferr, 0);
    chk("mid_rst_count", fcnt, 0);
    chk("mid_rst_acc",   acc,  0);
    @(negedge clk);
    reset_n = 1'b1;
    cnt_exp = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("no_stale_valid", fv, 0);
    end
    do_item(80'h96_01, 8'd7, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/varint_field_decoder.md
# varint_field_decoder

Downstream consumer of the varint output FIFO controller. Accepts one raw varint (up to 10 bytes, little-endian base-128) plus its field index through the `varint_data_valid`/`varint_data_accepted` handshake. Decodes it at one byte per cycle into a 64-bit value and presents the result with index, length and error flag on a valid/ready output toward the field record writer.

## Interface
- `INDEX_W`, default 8: width of the field index carried alongside each varint.
- `ZIGZAG`, default 0: 1 applies protobuf zigzag (sint) decoding to every output value; 0 passes the value through raw.
- `clk` in 1: single clock; all logic is rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `varint_data_valid` in 1: upstream holds a varint ready; held until accepted.
- `varint_data` in 80: raw varint bytes; byte k is `[8k+7:8k]`, byte 0 is first on the wire.
- `varint_index` in INDEX_W: field index paired with `varint_data`.
- `varint_data_accepted` out 1: one-cycle capture pulse to upstream.
- `field_valid` out 1: decoded result available.
- `field_ready` in 1: downstream takes the result.
- `field_value` out 64: decoded value, zigzagged if `ZIGZAG=1`.
- `field_index` out INDEX_W: captured index.
- `field_len` out 4: bytes consumed, 1..10.
- `field_error` out 1: malformed varint.
- `field_count` out 32: results handed off; saturates at 0xFFFF_FFFF.

## Operation
- States, one-hot: IDLE, DECODE, OUTPUT.
- **IDLE**
  - `varint_data_accepted` = `varint_data_valid` (combinational, asserted only in IDLE).
  - On accept: capture data and index, clear accumulator and byte counter k, go to DECODE.
- **DECODE**, one byte per cycle:
  - `acc |= byte[k][6:0] << 7k`.
  - If `byte[k][7]==0` or k==9: set `field_len`=k+1 and go to OUTPUT.
  - Otherwise k++.
- **Error rules**
  - Error if k==9 and `byte[9][7]==1` (no terminator).
  - Error if k==9 and `byte[9][6:1]!=0` (exceeds 64 bits).
  - On error, `field_value` holds the accumulated low 64 bits. Only `byte[9][0]` contributes, to bit 63.
- **Zigzag**: applied at the DECODE→OUTPUT transition as `(acc>>1) ^ -(acc&1)`.
- **OUTPUT**
  - `field_valid`=1; all field outputs held stable.
  - When `field_ready`=1: `field_count` increments (saturating) and the state returns to IDLE.
  - `varint_data_accepted`=0 throughout DECODE and OUTPUT, even if upstream is valid.
- Bytes after the terminator are ignored and may hold any value.
- Illegal or unreachable state: next state is IDLE.

## Timing
- **Reset** (`reset_n` low, asynchronous)
  - State goes to IDLE.
  - `varint_data_accepted`=0 (upstream is also expected reset), `field_valid`=0, `field_value`=0, `field_index`=0, `field_len`=0, `field_error`=0, `field_count`=0.
  - Deassertion is synchronised externally.
  - Reset mid-DECODE or mid-OUTPUT discards the captured varint; no result is emitted.
- **Latency**: an accept in cycle 0 with an n-byte varint gives `field_valid` in cycle n+1.
- **Throughput**: the next accept is no earlier than the cycle after the `field_valid && field_ready` handshake. The IDLE cycle is mandatory, so an n-byte varint occupies at least n+2 cycles.
- `field_valid` never drops without `field_ready`.
- `field_valid` and the field outputs are registered.

## Structure
- **Shared package `varint_pkg`**:
  - state one-hot encodings: IDLE=3'b001, DECODE=3'b010, OUTPUT=3'b100
  - `VARINT_MAX_BYTES`=10
  - `VARINT_RAW_W`=80
  - `VARINT_VAL_W`=64
  - field-length width 4
- **Single module.** Zigzag is a one-line expression, and the byte mux is indexed by k; neither warrants a sub-module.
- Expected size: ~150–200 lines.

## Test plan
- **Single byte**: data=80'h01, index=5, `field_ready`=1 → accepted pulse in cycle 0; `field_valid` in cycle 2 with value=1, len=1, index=5, error=0.
- **Two bytes**: data[15:0]=16'h02AC → value=300, len=2, `field_valid` in cycle 3.
- **Maximum length**: bytes 0–8 = 0xFF, byte 9 = 0x01 → value=64'hFFFF_FFFF_FFFF_FFFF, len=10, error=0.
- **Malformed**:
  - byte 9 = 0x80 with bytes 0–8 = 0xFF → error=1, len=10.
  - byte 9 = 0x02 → error=1.
- **Backpressure**: hold `field_ready`=0 for 5 cycles while upstream is valid → outputs stable, no accepted pulse; after `field_ready`=1, `field_count` increments by 1 and the next accept occurs in IDLE.
- **Zigzag and reset**:
  - `ZIGZAG`=1, data=80'h03 → value=64'hFFFF_FFFF_FFFF_FFFE.
  - Assert `reset_n` low mid-DECODE → all outputs 0 immediately; no stale `field_valid` after release.
